syn_fifo_prog: RTL and testbench
================================

// Module: syn_fifo_prog
// PURPOSE
//   Single-clock FIFO with parametrised width, any integer depth (not only 2^n), occupancy count,
//   runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a
//   selectable standard or first-word-fall-through (FWFT) read mode. Buffers between same-clock
//   producer/consumer stages, alongside the dual-clock FIFO in the same codebase.
// PARAMETERS
//   DEPTH  16  capacity in words, any integer >= 2
//   WIDTH  8   data width in bits
//   FWFT   0   0: standard registered read; 1: first-word-fall-through
//   CNT_W  $clog2(DEPTH+1)  derived localparam: width of count/threshold buses
// PORTS
//   clk            in   1      clock, all logic on posedge
//   rst            in   1      synchronous reset, active-high
//   winc           in   1      write request
//   wdata          in   WIDTH  write data
//   wfull          out  1      count == DEPTH
//   walmost_full   out  1      count >= afull_th
//   wovf           out  1      sticky: winc while wfull
//   rinc           in   1      read request (FWFT: pop the word on rdata)
//   rdata          out  WIDTH  read data
//   rempty         out  1      no word readable
//   ralmost_empty  out  1      count <= aempty_th
//   rudf           out  1      sticky: rinc while rempty
//   afull_th       in   CNT_W  almost-full threshold, quasi-static
//   aempty_th      in   CNT_W  almost-empty threshold, quasi-static
//   count          out  CNT_W  words stored (FWFT: includes word held on rdata)
// BEHAVIOUR
//   - Reset: one clk with rst=1 clears pointers, count=0, rempty=1, wfull=0, walmost_full=0,
//     ralmost_empty=1, wovf=0, rudf=0, rdata=0; RAM contents not cleared. Reset mid-operation
//     discards all stored words; winc/rinc in the reset cycle are ignored.
//   - Accept: wen = winc & ~wfull; ren = rinc & ~rempty. No write-through-when-full.
//   - Pointers 0..DEPTH-1, wrap DEPTH-1 -> 0 explicitly (non-2^n depth); no extra wrap bit, full/empty from count.
//   - count: +1 on wen only, -1 on ren only, unchanged on both or neither; never exceeds DEPTH.
//   - All status outputs are registers updated on the same edge as count from next-count
//     (no combinational path from winc/rinc to flags). Thresholds compared unsigned.
//   - Standard (FWFT=0): rdata registered, valid the cycle after the ren edge, holds otherwise.
//     Write at edge N into empty FIFO -> rempty=0 after edge N; ren possible in cycle N+1.
//   - FWFT=1: one-word output register; head word on rdata whenever rempty=0; rinc pops it.
//     Write at edge N into empty FIFO -> rempty=0 and rdata valid after edge N+1.
//     count increments after edge N; rempty reflects output register occupancy.
//     Back-to-back pops at 1 word/cycle when >=2 words stored; capacity still exactly DEPTH.
//   - Simultaneous wen+ren when count==1 (FWFT): popped word leaves, new word reaches rdata
//     within the 2-cycle write latency; rempty may pulse 1 for one cycle, never drops data.
//   - wovf/rudf set on the offending edge, cleared only by rst; rejected request has no other effect.
// STRUCTURE
//   - Package fifo_pkg: ptr/count width functions, mode constants FIFO_STD=0 / FIFO_FWFT=1.
//   - Sub-module fifo_ram: simple dual-port array, sync write, registered read with read enable;
//     top holds pointers, count, flags and FWFT output stage (generate on FWFT).
// TESTING
//   - DEPTH=5,WIDTH=8,FWFT=0: write 0x11..0x55 -> wfull=1, count=5; 6th write -> wovf=1, data intact; read 5 -> 0x11..0x55 in order.
//   - DEPTH=5: 12 interleaved write/read pairs -> pointers wrap 4->0, order preserved, count stays 1.
//   - Empty, rinc=1 -> rudf=1, rempty=1, count=0; full with winc=rinc=1 -> read accepted, write rejected, count=4.
//   - afull_th=4, aempty_th=1: fill 0->5 -> walmost_full rises after 4th write; ralmost_empty falls after 2nd write.
//   - FWFT=1: write 0xA5 at edge N -> rdata=0xA5, rempty=0 after N+1; rinc pop -> rempty=1; stream 8 words at 1/cycle in order.
//   - Fill 3 words, assert rst one cycle with winc=1 -> count=0, rempty=1, flags cleared, next read returns new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single- and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
module fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata_reg <= '0;
    else if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/syn_fifo_prog.sv
// Single-clock FIFO, arbitrary depth, programmable thresholds, sticky error
// flags and optional first-word-fall-through output stage.
module syn_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int FWFT  = FIFO_STD,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  output logic             wovf,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic             rudf,
  input  logic [CNT_W-1:0] afull_th,
  input  logic [CNT_W-1:0] aempty_th,
  output logic [CNT_W-1:0] count
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [AW-1:0]    wptr_reg, rptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wfull_reg, rempty_reg, afull_reg, aempty_reg, wovf_reg, rudf_reg;
  logic             wen, ren, ram_re, rempty_next;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign wen = winc & ~wfull_reg;
  assign ren = rinc & ~rempty_reg;

  always_comb begin
    count_next = count_reg;
    if (wen && !ren)      count_next = count_reg + CNT_W'(1);
    else if (ren && !wen) count_next = count_reg - CNT_W'(1);
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // mem_cnt tracks words still in the array; the head word lives in the RAM read register.
      logic [CNT_W-1:0] mem_cnt_reg, mem_cnt_next;
      logic             out_valid_reg, out_valid_next;

      always_comb begin
        ram_re         = (mem_cnt_reg != '0) && (!out_valid_reg || ren);
        out_valid_next = ram_re || (out_valid_reg && !ren);
        mem_cnt_next   = mem_cnt_reg;
        if (wen && !ram_re)      mem_cnt_next = mem_cnt_reg + CNT_W'(1);
        else if (ram_re && !wen) mem_cnt_next = mem_cnt_reg - CNT_W'(1);
        rempty_next    = !out_valid_next;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          mem_cnt_reg   <= '0;
          out_valid_reg <= 1'b0;
        end else begin
          mem_cnt_reg   <= mem_cnt_next;
          out_valid_reg <= out_valid_next;
        end
      end
    end else begin : g_std
      assign ram_re      = ren;
      assign rempty_next = (count_next == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      count_reg  <= '0;
      wfull_reg  <= 1'b0;
      rempty_reg <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      wovf_reg   <= 1'b0;
      rudf_reg   <= 1'b0;
    end else begin
      if (wen)    wptr_reg <= ptr_inc(wptr_reg);
      if (ram_re) rptr_reg <= ptr_inc(rptr_reg);
      count_reg  <= count_next;
      wfull_reg  <= (count_next == DEPTH_C);
      rempty_reg <= rempty_next;
      afull_reg  <= (count_next >= afull_th);
      aempty_reg <= (count_next <= aempty_th);
      wovf_reg   <= wovf_reg | (winc & wfull_reg);
      rudf_reg   <= rudf_reg | (rinc & rempty_reg);
    end
  end

  fifo_ram #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wen),
    .waddr(wptr_reg),
    .wdata(wdata),
    .re   (ram_re),
    .raddr(rptr_reg),
    .rdata(rdata)
  );

  assign wfull         = wfull_reg;
  assign walmost_full  = afull_reg;
  assign wovf          = wovf_reg;
  assign rempty        = rempty_reg;
  assign ralmost_empty = aempty_reg;
  assign rudf          = rudf_reg;
  assign count         = count_reg;

endmodule

// File: tb/tb_syn_fifo_prog.sv
// Drives a standard-mode and an FWFT instance with identical traffic and
// compares both against queue-based reference models.
module tb_syn_fifo_prog;

  localparam int DS = 5;
  localparam int DF = 6;
  localparam int CW = 3;

  typedef struct {
    logic [7:0] d;
    int         e;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, winc, rinc;
  logic [7:0]    wdata;
  logic [CW-1:0] s_ath, s_eth, f_ath, f_eth;

  logic          s_wfull, s_afull, s_ovf_o, s_rempty, s_aempty, s_udf_o;
  logic [7:0]    s_rdata;
  logic [CW-1:0] s_count;
  logic          f_wfull, f_afull, f_ovf_o, f_rempty, f_aempty, f_udf_o;
  logic [7:0]    f_rdata;
  logic [CW-1:0] f_count;

  always #5 clk = ~clk;

  syn_fifo_prog #(.DEPTH(DS), .WIDTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata),
    .wfull(s_wfull), .walmost_full(s_afull), .wovf(s_ovf_o),
    .rinc(rinc), .rdata(s_rdata), .rempty(s_rempty),
    .ralmost_empty(s_aempty), .rudf(s_udf_o),
    .afull_th(s_ath), .aempty_th(s_eth), .count(s_count)
  );

  syn_fifo_prog #(.DEPTH(DF), .WIDTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata),
    .wfull(f_wfull), .walmost_full(f_afull), .wovf(f_ovf_o),
    .rinc(rinc), .rdata(f_rdata), .rempty(f_rempty),
    .ralmost_empty(f_aempty), .rudf(f_udf_o),
    .afull_th(f_ath), .aempty_th(f_eth), .count(f_count)
  );

  // Reference state: plain queues; an FWFT word is visible once its write edge has passed.
  logic [7:0] sq[$];
  logic [7:0] s_rd;
  bit         s_ovf, s_udf;
  ent_t       fq[$];
  bit         f_vis, f_ovf, f_udf;
  bit         just_rst;
  int         cyc;
  int         vectors;
  int         miscompares;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit wi, input logic [7:0] wd, input bit ri);
    bit   s_full, s_empty, f_full;
    ent_t e;
    rst   = r;
    winc  = wi;
    wdata = wd;
    rinc  = ri;
    @(posedge clk);
    cyc++;
    if (r) begin
      sq.delete();
      fq.delete();
      s_rd = 8'h00;
      s_ovf = 0; s_udf = 0; f_ovf = 0; f_udf = 0; f_vis = 0;
      just_rst = 1;
    end else begin
      just_rst = 0;
      s_full  = (sq.size() == DS);
      s_empty = (sq.size() == 0);
      if (wi && s_full)  s_ovf = 1;
      if (ri && s_empty) s_udf = 1;
      if (ri && !s_empty) s_rd = sq.pop_front();
      if (wi && !s_full)  sq.push_back(wd);

      f_full = (fq.size() == DF);
      if (wi && f_full) f_ovf = 1;
      if (ri && !f_vis) f_udf = 1;
      if (ri && f_vis)  e = fq.pop_front();
      if (wi && !f_full) begin
        e.d = wd;
        e.e = cyc;
        fq.push_back(e);
      end
      f_vis = (fq.size() > 0) && (fq[0].e < cyc);
    end
    #1;
    $display("cyc %0d rst=%0b w=%0b d=%02h r=%0b | std cnt=%0d rd=%02h emp=%0b | fwft cnt=%0d rd=%02h emp=%0b",
             cyc, r, wi, wd, ri, s_count, s_rdata, s_rempty, f_count, f_rdata, f_rempty);

    chk("std_count",  32'(s_count),  32'(sq.size()));
    chk("std_wfull",  32'(s_wfull),  32'(sq.size() == DS));
    chk("std_afull",  32'(s_afull),  just_rst ? 32'd0 : 32'(sq.size() >= int'(s_ath)));
    chk("std_aempty", 32'(s_aempty), just_rst ? 32'd1 : 32'(sq.size() <= int'(s_eth)));
    chk("std_rempty", 32'(s_rempty), 32'(sq.size() == 0));
    chk("std_ovf",    32'(s_ovf_o),  32'(s_ovf));
    chk("std_udf",    32'(s_udf_o),  32'(s_udf));
    chk("std_rdata",  32'(s_rdata),  32'(s_rd));

    chk("fwft_count",  32'(f_count),  32'(fq.size()));
    chk("fwft_wfull",  32'(f_wfull),  32'(fq.size() == DF));
    chk("fwft_afull",  32'(f_afull),  just_rst ? 32'd0 : 32'(fq.size() >= int'(f_ath)));
    chk("fwft_aempty", 32'(f_aempty), just_rst ? 32'd1 : 32'(fq.size() <= int'(f_eth)));
    chk("fwft_rempty", 32'(f_rempty), 32'(!f_vis));
    chk("fwft_ovf",    32'(f_ovf_o),  32'(f_ovf));
    chk("fwft_udf",    32'(f_udf_o),  32'(f_udf));
    if (just_rst)   chk("fwft_rdata_rst", 32'(f_rdata), 32'd0);
    else if (f_vis) chk("fwft_rdata",     32'(f_rdata), 32'(fq[0].d));
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; just_rst = 0;
    s_rd = 8'h00; s_ovf = 0; s_udf = 0; f_ovf = 0; f_udf = 0; f_vis = 0;
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    s_ath = 3'd4; s_eth = 3'd1; f_ath = 3'd4; f_eth = 3'd1;

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);

    // Fill to full and beyond, then drain past empty.
    for (int i = 1; i <= 5; i++) step(0, 1, 8'(i * 17), 0);
    step(0, 1, 8'h66, 0);
    step(0, 1, 8'h77, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);

    // Interleaved traffic around one stored word exercises pointer wrap.
    step(0, 1, 8'h01, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 8'(8'h20 + i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    // Full with simultaneous write and read.
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h40 + i), 0);
    step(0, 1, 8'hEE, 1);
    step(0, 1, 8'hEF, 1);
    step(1, 0, 8'h00, 0);

    // Single word latency and pop, then a continuous stream.
    step(0, 1, 8'hA5, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 11; i++) step(0, i < 8, 8'(8'hB0 + i), 1);

    // Reset mid-operation with a write request present.
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hC0 + i), 0);
    step(1, 1, 8'hCC, 0);
    step(0, 1, 8'h5A, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    // Randomised traffic with occasional threshold changes and resets.
    for (int i = 0; i < 400; i++) begin
      int wp;
      if (i % 40 == 0) begin
        s_ath = 3'($urandom_range(0, DS));
        s_eth = 3'($urandom_range(0, DS));
        f_ath = 3'($urandom_range(0, DF));
        f_eth = 3'($urandom_range(0, DF));
      end
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < wp),
           8'($urandom), ($urandom_range(0, 99) < 50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
